// File: rtl/fir_sched_pkg.sv
// rtl/fir_sched_pkg.sv - shared types, default widths and Q15 constants for the FIR MAC scheduler
package fir_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_ROUND,
        S_OUT
    } state_t;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_TAPS   = 33;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_COEF_W = 16;
    localparam int DEF_ACC_W  = 40;

    localparam int     Q15_SHIFT = 15;
    localparam longint Q15_ROUND = longint'(1) << 14;

    localparam longint SAT_MAX = 32767;
    localparam longint SAT_MIN = -32768;

    // Saturation limits for an arbitrary signed result width.
    function automatic longint sat_hi(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_lo(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant among pending leads, search starting after last grant
module rr_arbiter
    import fir_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CH_W-1:0]   i_last_grant,
    output logic [NUM_CH-1:0] o_grant,
    output logic [CH_W-1:0]   o_grant_idx,
    output logic              o_any
);

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        for (int off = 1; off <= NUM_CH; off++) begin
            if (!o_any && i_req[(int'(i_last_grant) + off) % NUM_CH]) begin
                o_any       = 1'b1;
                o_grant_idx = CH_W'((int'(i_last_grant) + off) % NUM_CH);
                o_grant[(int'(i_last_grant) + off) % NUM_CH] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fir_mac_scheduler.sv
// rtl/fir_mac_scheduler.sv - one Q15 MAC time-shared across leads, tap-serial FIR with RR arbitration
module fir_mac_scheduler
    import fir_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int TAPS   = DEF_TAPS,
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          in_valid,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    output logic [NUM_CH-1:0]          in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(NUM_CH)-1:0]  out_ch,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_sat,
    input  logic                       coef_wr_en,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic [COEF_W-1:0]          coef_wr_data,
    output logic                       coef_err,
    output logic                       busy
);

    localparam int CH_W   = $clog2(NUM_CH);
    localparam int K_W    = $clog2(TAPS);
    localparam int PROD_W = COEF_W + DATA_W;

    localparam logic signed [ACC_W-1:0] L_ROUND  = ACC_W'(Q15_ROUND);
    localparam logic signed [ACC_W-1:0] L_SAT_HI = ACC_W'(sat_hi(DATA_W));
    localparam logic signed [ACC_W-1:0] L_SAT_LO = ACC_W'(sat_lo(DATA_W));

    state_t r_state;
    state_t w_next_state;

    logic [NUM_CH-1:0]        r_pending;
    logic signed [DATA_W-1:0] r_buf   [NUM_CH];
    logic signed [DATA_W-1:0] r_dline [NUM_CH][TAPS];
    logic signed [COEF_W-1:0] r_coef  [TAPS];

    logic [CH_W-1:0]          r_ch;
    logic [NUM_CH-1:0]        r_grant_oh;
    logic [CH_W-1:0]          r_last_grant;
    logic [K_W-1:0]           r_k;
    logic signed [ACC_W-1:0]  r_acc;

    logic [DATA_W-1:0]        r_out_data;
    logic                     r_out_sat;
    logic [CH_W-1:0]          r_out_ch;
    logic                     r_coef_err;

    logic [NUM_CH-1:0]        w_accept;
    logic [NUM_CH-1:0]        w_clear;
    logic [NUM_CH-1:0]        w_grant_oh;
    logic [CH_W-1:0]          w_grant_idx;
    logic                     w_any;
    logic                     w_coef_wr_ok;
    logic                     w_last_tap;

    logic signed [PROD_W-1:0] w_coef_ext;
    logic signed [PROD_W-1:0] w_x_ext;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_rsum;
    logic signed [ACC_W-1:0]  w_rshift;
    logic                     w_sat_hi;
    logic                     w_sat_lo;
    logic [DATA_W-1:0]        w_result;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .i_req        (r_pending),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant_oh),
        .o_grant_idx  (w_grant_idx),
        .o_any        (w_any)
    );

    assign w_accept     = in_valid & ~r_pending;
    assign w_clear      = (r_state == S_LOAD) ? r_grant_oh : '0;
    assign w_coef_wr_ok = coef_wr_en && (r_state == S_IDLE) && (int'(coef_addr) < TAPS);
    assign w_last_tap   = (r_k == K_W'(TAPS - 1));

    // Full-precision signed product, then sign-extended into the accumulator width.
    assign w_coef_ext = $signed({{DATA_W{r_coef[r_k][COEF_W-1]}}, r_coef[r_k]});
    assign w_x_ext    = $signed({{COEF_W{r_dline[r_ch][r_k][DATA_W-1]}}, r_dline[r_ch][r_k]});
    assign w_prod     = w_coef_ext * w_x_ext;
    assign w_prod_ext = $signed({{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod});

    assign w_rsum   = r_acc + L_ROUND;
    assign w_rshift = w_rsum >>> Q15_SHIFT;
    assign w_sat_hi = (w_rshift > L_SAT_HI);
    assign w_sat_lo = (w_rshift < L_SAT_LO);
    assign w_result = w_sat_hi ? DATA_W'(L_SAT_HI) :
                      w_sat_lo ? DATA_W'(L_SAT_LO) : w_rshift[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next_state = S_LOAD;
            S_LOAD:  w_next_state = S_MAC;
            S_MAC:   if (w_last_tap) w_next_state = S_ROUND;
            S_ROUND: w_next_state = S_OUT;
            S_OUT:   if (out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Input buffers fill independently of the engine; a full lead ignores in_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
            for (int c = 0; c < NUM_CH; c++) r_buf[c] <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clear) | w_accept;
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_accept[c]) r_buf[c] <= in_data[c*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) r_coef[k] <= '0;
        end else if (w_coef_wr_ok) begin
            r_coef[coef_addr] <= coef_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < TAPS; k++) r_dline[c][k] <= '0;
            end
        end else if (r_state == S_LOAD) begin
            for (int k = TAPS - 1; k > 0; k--) r_dline[r_ch][k] <= r_dline[r_ch][k-1];
            r_dline[r_ch][0] <= r_buf[r_ch];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ch         <= '0;
            r_grant_oh   <= '0;
            r_last_grant <= CH_W'(NUM_CH - 1);
            r_k          <= '0;
            r_acc        <= '0;
            r_out_data   <= '0;
            r_out_sat    <= 1'b0;
            r_out_ch     <= '0;
            r_coef_err   <= 1'b0;
        end else begin
            r_coef_err <= coef_wr_en && !w_coef_wr_ok;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_ch         <= w_grant_idx;
                        r_grant_oh   <= w_grant_oh;
                        r_last_grant <= w_grant_idx;
                    end
                end
                S_LOAD: begin
                    r_k   <= '0;
                    r_acc <= '0;
                end
                S_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    if (!w_last_tap) r_k <= r_k + K_W'(1);
                end
                S_ROUND: begin
                    r_out_data <= w_result;
                    r_out_sat  <= w_sat_hi | w_sat_lo;
                    r_out_ch   <= r_ch;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = ~r_pending;
    assign out_valid = (r_state == S_OUT);
    assign out_ch    = r_out_ch;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign coef_err  = r_coef_err;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// tb/tb_fir_mac_scheduler.sv - directed self-checking bench for fir_mac_scheduler
module tb_fir_mac_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_valid;
    logic [63:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;
    logic [15:0] out_data;
    logic        out_sat;
    logic        coef_wr_en;
    logic [5:0]  coef_addr;
    logic [15:0] coef_wr_data;
    logic        coef_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fir_mac_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ch       (out_ch),
        .out_data     (out_data),
        .out_sat      (out_sat),
        .coef_wr_en   (coef_wr_en),
        .coef_addr    (coef_addr),
        .coef_wr_data (coef_wr_data),
        .coef_err     (coef_err),
        .busy         (busy)
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b1;
        coef_wr_en = 1'b0; coef_addr = '0; coef_wr_data = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic write_coef(input int addr, input logic [15:0] val);
        coef_wr_en = 1'b1; coef_addr = 6'(addr); coef_wr_data = val;
        @(negedge clk);
        coef_wr_en = 1'b0;
    endtask

    task automatic send(input int c, input logic [15:0] val);
        in_valid[c] = 1'b1;
        in_data[c*16 +: 16] = val;
        @(negedge clk);
        in_valid[c] = 1'b0;
    endtask

    task automatic wait_out(input int limit, output logic got, output logic [1:0] ch,
                            output logic [15:0] data, output logic sat, output int n);
        n = 0;
        while (!out_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
        got = out_valid; ch = out_ch; data = out_data; sat = out_sat;
        if (got && out_ready) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 4'hF) begin failures++; $display("FAIL reset_in_ready got=%h exp=f", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 16'h0 || out_ch !== 2'd0 || out_sat !== 1'b0)
            begin failures++; $display("FAIL reset_outputs data=%h ch=%0d sat=%b exp 0/0/0", out_data, out_ch, out_sat); end
        checks++; if (coef_err !== 1'b0 || busy !== 1'b0)
            begin failures++; $display("FAIL reset_err_busy err=%b busy=%b exp 0/0", coef_err, busy); end
    endtask

    task automatic test_unity_latency();
        logic got, sat; logic [1:0] ch; logic [15:0] d; int n;
        do_reset();
        write_coef(0, 16'd32767);
        checks++; if (coef_err !== 1'b0) begin failures++; $display("FAIL idle_write_err got=%b exp=0", coef_err); end
        send(0, 16'd1000);
        wait_out(100, got, ch, d, sat, n);
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL unity_timeout got=%b exp=1", got); end
        checks++; if (n != 36) begin failures++; $display("FAIL unity_latency got=%0d exp=36", n); end
        checks++; if (d !== 16'd1000 || ch !== 2'd0 || sat !== 1'b0)
            begin failures++; $display("FAIL unity_result data=%0d ch=%0d sat=%b exp 1000/0/0", d, ch, sat); end
    endtask

    task automatic test_saturation();
        logic got, sat; logic [1:0] ch; logic [15:0] d; int n;
        logic [15:0] first_d; logic first_sat;
        do_reset();
        for (int a = 0; a < 33; a++) write_coef(a, 16'd1024);
        first_d = '0; first_sat = 1'b1; got = 1'b0; ch = '0; d = '0; sat = 1'b0;
        for (int i = 0; i < 33; i++) begin
            send(1, 16'h7FFF);
            wait_out(100, got, ch, d, sat, n);
            if (i == 0) begin first_d = d; first_sat = sat; end
        end
        checks++; if (first_d !== 16'd1024 || first_sat !== 1'b0)
            begin failures++; $display("FAIL sat_first data=%0d sat=%b exp 1024/0", first_d, first_sat); end
        checks++; if (got !== 1'b1 || d !== 16'h7FFF || sat !== 1'b1 || ch !== 2'd1)
            begin failures++; $display("FAIL sat_pos got=%b data=%h sat=%b ch=%0d exp 1/7fff/1/1", got, d, sat, ch); end
        for (int i = 0; i < 33; i++) begin
            send(1, 16'h8000);
            wait_out(100, got, ch, d, sat, n);
        end
        checks++; if (got !== 1'b1 || d !== 16'h8000 || sat !== 1'b1)
            begin failures++; $display("FAIL sat_neg got=%b data=%h sat=%b exp 1/8000/1", got, d, sat); end
    endtask

    task automatic test_round_robin();
        logic got, sat; logic [1:0] ch; logic [15:0] d; int n;
        do_reset();
        write_coef(0, 16'd32767);
        for (int r = 0; r < 2; r++) begin
            in_valid = 4'hF;
            for (int c = 0; c < 4; c++) in_data[c*16 +: 16] = 16'(10 * (c + 1) + 40 * r);
            @(negedge clk);
            in_valid = 4'h0;
            for (int i = 0; i < 4; i++) begin
                wait_out(100, got, ch, d, sat, n);
                checks++;
                if (got !== 1'b1 || ch !== 2'(i) || d !== 16'(10 * (i + 1) + 40 * r))
                    begin failures++; $display("FAIL rr_round%0d_slot%0d got=%b ch=%0d data=%0d exp ch=%0d data=%0d",
                                                r, i, got, ch, d, i, 10 * (i + 1) + 40 * r); end
            end
        end
    endtask

    task automatic test_isolation();
        logic got, sat; logic [1:0] ch; logic [15:0] d; int n;
        do_reset();
        write_coef(1, 16'd32767);
        send(2, 16'd500);
        wait_out(100, got, ch, d, sat, n);
        checks++; if (got !== 1'b1 || ch !== 2'd2 || d !== 16'd0)
            begin failures++; $display("FAIL iso_first got=%b ch=%0d data=%0d exp 1/2/0", got, ch, d); end
        send(3, 16'd7);
        wait_out(100, got, ch, d, sat, n);
        checks++; if (got !== 1'b1 || ch !== 2'd3 || d !== 16'd0)
            begin failures++; $display("FAIL iso_lead3 got=%b ch=%0d data=%0d exp 1/3/0", got, ch, d); end
        send(2, 16'd0);
        wait_out(100, got, ch, d, sat, n);
        checks++; if (got !== 1'b1 || ch !== 2'd2 || d !== 16'd500)
            begin failures++; $display("FAIL iso_second got=%b ch=%0d data=%0d exp 1/2/500", got, ch, d); end
    endtask

    task automatic test_stall();
        logic got, sat; logic [1:0] ch; logic [15:0] d; int n; int bad;
        do_reset();
        write_coef(0, 16'd32767);
        out_ready = 1'b0;
        send(0, 16'd5);
        wait_out(100, got, ch, d, sat, n);
        checks++; if (got !== 1'b1 || d !== 16'd5)
            begin failures++; $display("FAIL stall_first got=%b data=%0d exp 1/5", got, d); end
        send(1, 16'd11);
        send(2, 16'd12);
        checks++; if (in_ready !== 4'b1001)
            begin failures++; $display("FAIL stall_in_ready got=%b exp=1001", in_ready); end
        in_valid[1] = 1'b1;
        in_data[16 +: 16] = 16'd999;
        bad = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== 16'd5 || out_ch !== 2'd0) bad++;
        end
        in_valid[1] = 1'b0;
        checks++; if (bad != 0) begin failures++; $display("FAIL stall_hold unstable_cycles=%0d exp=0", bad); end
        out_ready = 1'b1;
        @(negedge clk);
        wait_out(100, got, ch, d, sat, n);
        checks++; if (got !== 1'b1 || ch !== 2'd1 || d !== 16'd11)
            begin failures++; $display("FAIL stall_lead1 got=%b ch=%0d data=%0d exp 1/1/11", got, ch, d); end
        wait_out(100, got, ch, d, sat, n);
        checks++; if (got !== 1'b1 || ch !== 2'd2 || d !== 16'd12)
            begin failures++; $display("FAIL stall_lead2 got=%b ch=%0d data=%0d exp 1/2/12", got, ch, d); end
    endtask

    task automatic test_coef_err_and_reset();
        logic got, sat; logic [1:0] ch; logic [15:0] d; int n; int seen;
        do_reset();
        write_coef(0, 16'd32767);
        send(0, 16'd100);
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL err_busy got=%b exp=1", busy); end
        coef_wr_en = 1'b1; coef_addr = 6'd0; coef_wr_data = 16'd0;
        @(negedge clk);
        coef_wr_en = 1'b0;
        checks++; if (coef_err !== 1'b1) begin failures++; $display("FAIL err_pulse got=%b exp=1", coef_err); end
        @(negedge clk);
        checks++; if (coef_err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", coef_err); end
        wait_out(100, got, ch, d, sat, n);
        checks++; if (got !== 1'b1 || d !== 16'd100)
            begin failures++; $display("FAIL err_coef_kept got=%b data=%0d exp 1/100", got, d); end
        send(0, 16'd200);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 4'hF || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 16'h0 ||
                      out_sat !== 1'b0 || out_ch !== 2'd0 || coef_err !== 1'b0)
            begin failures++; $display("FAIL midmac_reset rdy=%h ov=%b busy=%b data=%h sat=%b ch=%0d err=%b exp f/0/0/0/0/0/0",
                                        in_ready, out_valid, busy, out_data, out_sat, out_ch, coef_err); end
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL midmac_no_out valid_cycles=%0d exp=0", seen); end
        send(0, 16'd300);
        wait_out(100, got, ch, d, sat, n);
        checks++; if (got !== 1'b1 || d !== 16'd0)
            begin failures++; $display("FAIL reset_coefs got=%b data=%0d exp 1/0", got, d); end
    endtask

    initial begin
        reset = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b1;
        coef_wr_en = 1'b0; coef_addr = '0; coef_wr_data = '0;
        test_reset();
        test_unity_latency();
        test_saturation();
        test_round_robin();
        test_isolation();
        test_stall();
        test_coef_err_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
